// File: rtl/step_scheduler_if.sv
// Chart-playback bus between step_scheduler, the frame/chart sources and arrow_logic.
// master = environment side, slave = scheduler side.
interface step_scheduler_if #(
  parameter int AW    = 8,
  parameter int DW    = 8,
  parameter int DROPW = 8
);
  logic             frame_i;
  logic             start_i;
  logic             stop_i;
  logic             pause_i;
  logic [3:0]       lane_full_i;
  logic             rom_en_o;
  logic [AW-1:0]    rom_addr_o;
  logic [DW+3:0]    rom_data_i;
  logic [3:0]       spawn_o;
  logic             busy_o;
  logic             done_o;
  logic [AW-1:0]    step_idx_o;
  logic [DROPW-1:0] drop_cnt_o;

  modport master (
    output frame_i, start_i, stop_i, pause_i, lane_full_i, rom_data_i,
    input  rom_en_o, rom_addr_o, spawn_o, busy_o, done_o, step_idx_o, drop_cnt_o
  );

  modport slave (
    input  frame_i, start_i, stop_i, pause_i, lane_full_i, rom_data_i,
    output rom_en_o, rom_addr_o, spawn_o, busy_o, done_o, step_idx_o, drop_cnt_o
  );
endinterface

// File: rtl/step_scheduler.sv
// Step-chart sequencer: fetches {mask, delay} entries, counts accepted frame pulses and
// emits one-cycle per-lane spawn pulses; 2-cycle fetch, no backpressure (full lanes drop).
module step_scheduler #(
  parameter int AW    = 8,
  parameter int DW    = 8,
  parameter int LOOP  = 0,
  parameter int DROPW = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  step_scheduler_if.slave   bus
);
  localparam int SW = DROPW + 3;
  localparam logic [DROPW-1:0] DMAX = '1;

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, WAIT, DONE} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    cnt_q, cnt_d;
  logic [3:0]       mask_q, mask_d;
  logic [3:0]       spawn_q, spawn_d;
  logic [DROPW-1:0] drop_q, drop_d;
  logic             rom_en_q, rom_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [3:0]    rom_mask;
  logic [DW-1:0] rom_delay;
  logic [3:0]    hit;
  logic [2:0]    pop;
  logic [SW-1:0] drop_sum;

  assign rom_mask  = bus.rom_data_i[DW+3:DW];
  assign rom_delay = bus.rom_data_i[DW-1:0];

  always_comb begin
    hit      = mask_q & bus.lane_full_i;
    pop      = 3'(hit[0]) + 3'(hit[1]) + 3'(hit[2]) + 3'(hit[3]);
    drop_sum = SW'(drop_q) + SW'(pop);

    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    drop_d  = drop_q;
    spawn_d = '0;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start_i) begin
          addr_d  = '0;
          drop_d  = '0;
          state_d = FETCH;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        mask_d = rom_mask;
        cnt_d  = rom_delay;
        if (rom_mask == 4'b0000 && rom_delay == '0) begin
          if (LOOP != 0) begin
            addr_d  = '0;
            state_d = FETCH;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.frame_i && !bus.pause_i) begin
          if (cnt_q == '0) begin
            spawn_d = mask_q & ~bus.lane_full_i;
            drop_d  = (drop_sum > SW'(DMAX)) ? DMAX : drop_sum[DROPW-1:0];
            addr_d  = addr_q + AW'(1);
            state_d = FETCH;
          end else begin
            cnt_d = cnt_q - DW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over start and frame: nothing else moves this cycle.
    if (bus.stop_i) begin
      state_d = IDLE;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      mask_d  = mask_q;
      drop_d  = drop_q;
      spawn_d = '0;
    end

    rom_en_d = (state_d == FETCH);
    busy_d   = (state_d == FETCH) || (state_d == LOAD) || (state_d == WAIT);
    done_d   = (state_d == DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      mask_q   <= '0;
      spawn_q  <= '0;
      drop_q   <= '0;
      rom_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      spawn_q  <= spawn_d;
      drop_q   <= drop_d;
      rom_en_q <= rom_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.rom_en_o   = rom_en_q;
  assign bus.rom_addr_o = addr_q;
  assign bus.spawn_o    = spawn_q;
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.step_idx_o = addr_q;
  assign bus.drop_cnt_o = drop_q;
endmodule
